// File: rtl/dmem_sized.sv
// dmem_sized: byte/halfword/word data memory with little-endian byte lanes,
// registered sign/zero-extended loads, fault reporting and a post-reset clear sequencer.
module dmem_sized #(
    parameter int    DEPTH          = 256,
    parameter bit    CLEAR_ON_RESET = 1'b1,
    parameter string INIT_FILE      = ""
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        we,
    input  logic        re,
    input  logic [2:0]  funct3,
    input  logic [31:0] addr,
    input  logic [31:0] data_in,
    output logic [31:0] data_out,
    output logic        valid,
    output logic        fault,
    output logic        busy
);
    localparam int AW = $clog2(DEPTH);

    localparam logic [1:0] ST_RESET = 2'd0;
    localparam logic [1:0] ST_CLEAR = 2'd1;
    localparam logic [1:0] ST_READY = 2'd2;

    localparam logic [AW-1:0] CNT_ZERO = {AW{1'b0}};
    localparam logic [AW-1:0] CNT_ONE  = AW'(1);
    localparam logic [AW-1:0] CNT_LAST = AW'(DEPTH - 1);

    function automatic logic [31:0] load_extract(input logic [31:0] word,
                                                 input logic [2:0]  f3,
                                                 input logic [1:0]  lane);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        case (lane)
            2'b00:   b = word[7:0];
            2'b01:   b = word[15:8];
            2'b10:   b = word[23:16];
            default: b = word[31:24];
        endcase
        h = lane[1] ? word[31:16] : word[15:0];
        case (f3)
            3'b000:  r = {{24{b[7]}}, b};
            3'b001:  r = {{16{h[15]}}, h};
            3'b010:  r = word;
            3'b100:  r = {24'd0, b};
            3'b101:  r = {16'd0, h};
            default: r = 32'd0;
        endcase
        return r;
    endfunction

    function automatic logic [3:0] store_be(input logic [1:0] size, input logic [1:0] lane);
        logic [3:0] be;
        case (size)
            2'b00:   be = 4'b0001 << lane;
            2'b01:   be = lane[1] ? 4'b1100 : 4'b0011;
            2'b10:   be = 4'b1111;
            default: be = 4'b0000;
        endcase
        return be;
    endfunction

    // Right-aligned store data is replicated so every lane sees its byte.
    function automatic logic [31:0] store_data(input logic [1:0] size, input logic [31:0] d);
        logic [31:0] r;
        case (size)
            2'b00:   r = {4{d[7:0]}};
            2'b01:   r = {2{d[15:0]}};
            default: r = d;
        endcase
        return r;
    endfunction

    logic [1:0]    state_r;
    logic [1:0]    state_nxt_s;
    logic [AW-1:0] clr_cnt_r;
    logic [AW-1:0] clr_cnt_nxt_s;
    logic          clr_we_s;
    logic [AW-1:0] clr_idx_s;
    logic          busy_r;

    logic [31:0]   mem_r [DEPTH];
    logic [AW-1:0] widx_s;
    logic [31:0]   rd_word_s;
    logic          ld_legal_s;
    logic          st_legal_s;
    logic          misalign_s;
    logic          accept_s;
    logic          ld_ok_s;
    logic          ld_bad_s;
    logic          st_ok_s;
    logic          st_bad_s;
    logic [3:0]    st_be_s;
    logic [31:0]   st_data_s;
    logic [31:0]   data_out_r;
    logic          valid_r;
    logic          fault_r;
    logic          unused_addr_s;

    assign widx_s        = addr[AW+1:2];
    assign rd_word_s     = mem_r[widx_s];
    assign unused_addr_s = ^addr[31:AW+2];

    // Next-state logic: the exit from RESET already clears word 0 so the
    // whole sequence takes exactly DEPTH cycles after rst falls.
    always_comb begin
        state_nxt_s   = state_r;
        clr_cnt_nxt_s = clr_cnt_r;
        clr_we_s      = 1'b0;
        clr_idx_s     = clr_cnt_r;
        if (rst) begin
            state_nxt_s   = ST_RESET;
            clr_cnt_nxt_s = CNT_ZERO;
        end else begin
            case (state_r)
                ST_RESET: begin
                    if (CLEAR_ON_RESET) begin
                        clr_we_s      = 1'b1;
                        clr_idx_s     = CNT_ZERO;
                        clr_cnt_nxt_s = CNT_ONE;
                        state_nxt_s   = ST_CLEAR;
                    end else begin
                        state_nxt_s   = ST_READY;
                    end
                end
                ST_CLEAR: begin
                    clr_we_s = 1'b1;
                    if (clr_cnt_r == CNT_LAST) begin
                        state_nxt_s = ST_READY;
                    end else begin
                        clr_cnt_nxt_s = clr_cnt_r + CNT_ONE;
                    end
                end
                ST_READY: state_nxt_s = ST_READY;
                default:  state_nxt_s = ST_RESET;
            endcase
        end
    end

    // State, clear counter and registered busy flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r   <= ST_RESET;
            clr_cnt_r <= CNT_ZERO;
            busy_r    <= 1'b1;
        end else begin
            state_r   <= state_nxt_s;
            clr_cnt_r <= clr_cnt_nxt_s;
            busy_r    <= (state_nxt_s != ST_READY);
        end
    end

    // Request decode: legality, alignment and the per-lane write pattern.
    always_comb begin
        case (funct3)
            3'b000, 3'b001, 3'b010, 3'b100, 3'b101: ld_legal_s = 1'b1;
            default:                                ld_legal_s = 1'b0;
        endcase
        st_legal_s = (funct3[2] == 1'b0) && (funct3[1:0] != 2'b11);
        misalign_s = ((funct3[1:0] == 2'b01) && addr[0]) ||
                     ((funct3[1:0] == 2'b10) && (addr[1:0] != 2'b00));
        accept_s   = (state_r == ST_READY) && !rst;
        ld_ok_s    = accept_s && re && ld_legal_s && !misalign_s;
        ld_bad_s   = accept_s && re && !(ld_legal_s && !misalign_s);
        st_ok_s    = accept_s && we && st_legal_s && !misalign_s;
        st_bad_s   = accept_s && we && !(st_legal_s && !misalign_s);
        st_be_s    = store_be(funct3[1:0], addr[1:0]);
        st_data_s  = store_data(funct3[1:0], data_in);
    end

    // Array write port: clear sequencer or byte-lane store, never both.
    always_ff @(posedge clk) begin
        if (clr_we_s) begin
            mem_r[clr_idx_s] <= 32'd0;
        end else if (st_ok_s) begin
            for (int i = 0; i < 4; i++) begin
                if (st_be_s[i]) begin
                    mem_r[widx_s][8*i +: 8] <= st_data_s[8*i +: 8];
                end
            end
        end
    end

    // Registered load result; reading the pre-edge array gives read-first.
    always_ff @(posedge clk) begin
        if (rst) begin
            data_out_r <= 32'd0;
            valid_r    <= 1'b0;
            fault_r    <= 1'b0;
        end else begin
            valid_r <= ld_ok_s || ld_bad_s;
            fault_r <= ld_bad_s || st_bad_s;
            if (ld_ok_s) begin
                data_out_r <= load_extract(rd_word_s, funct3, addr[1:0]);
            end else if (ld_bad_s) begin
                data_out_r <= 32'd0;
            end else begin
                data_out_r <= data_out_r;
            end
        end
    end

    assign data_out = data_out_r;
    assign valid    = valid_r;
    assign fault    = fault_r;
    assign busy     = busy_r;

endmodule

// File: tb/tb_dmem_sized.sv
// Randomised scoreboard bench for dmem_sized against a byte-array reference model;
// a second instance covers contents surviving reset when the clear is disabled.
module tb_dmem_sized;
    localparam int DEPTH = 256;
    localparam int MEMB  = DEPTH * 4;

    typedef struct {
        logic        v;
        logic        f;
        logic [31:0] d;
        int          cyc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst, we, re;
    logic [2:0]  funct3;
    logic [31:0] addr, data_in, data_out;
    logic        valid, fault, busy;

    logic        nc_rst, nc_we, nc_re;
    logic [2:0]  nc_funct3;
    logic [31:0] nc_addr, nc_data_in, nc_data_out;
    logic        nc_valid, nc_fault, nc_busy;

    logic [7:0]  ref_mem [MEMB];
    exp_t        exp_q [$];
    logic [31:0] last_dout;
    bit          mon_en;
    int          cyc = 0;
    int          ntests = 0;
    int          nfail = 0;
    logic [2:0]  f3_tbl [8] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5, 3'd2, 3'd3, 3'd6};

    dmem_sized #(.DEPTH(DEPTH), .CLEAR_ON_RESET(1'b1), .INIT_FILE("")) dut (
        .clk(clk), .rst(rst), .we(we), .re(re), .funct3(funct3), .addr(addr),
        .data_in(data_in), .data_out(data_out), .valid(valid), .fault(fault), .busy(busy)
    );

    dmem_sized #(.DEPTH(16), .CLEAR_ON_RESET(1'b0), .INIT_FILE("")) dut_nc (
        .clk(clk), .rst(nc_rst), .we(nc_we), .re(nc_re), .funct3(nc_funct3), .addr(nc_addr),
        .data_in(nc_data_in), .data_out(nc_data_out), .valid(nc_valid), .fault(nc_fault),
        .busy(nc_busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        ntests++;
        if (act !== req) begin
            nfail++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    function automatic bit ld_legal(input logic [2:0] f3, input logic [31:0] a);
        int size;
        if (!(f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5})) return 1'b0;
        size = 1 << f3[1:0];
        return (int'(a[1:0]) % size) == 0;
    endfunction

    function automatic bit st_legal(input logic [2:0] f3, input logic [31:0] a);
        int size;
        if (!(f3 inside {3'd0, 3'd1, 3'd2})) return 1'b0;
        size = 1 << f3[1:0];
        return (int'(a[1:0]) % size) == 0;
    endfunction

    // Little-endian gather of 'size' bytes, then arithmetic sign extension.
    function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [31:0] a);
        int     size, base;
        longint v, half;
        size = 1 << f3[1:0];
        base = int'(a % 32'(MEMB));
        v = 0;
        for (int k = size - 1; k >= 0; k--) v = v * 256 + longint'(ref_mem[(base + k) % MEMB]);
        half = longint'(1) << (8 * size - 1);
        if (!f3[2] && size < 4 && v >= half) v = v - 2 * half;
        return v[31:0];
    endfunction

    function automatic void ref_store(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d);
        int          size, base;
        logic [31:0] t;
        size = 1 << f3[1:0];
        base = int'(a % 32'(MEMB));
        for (int k = 0; k < size; k++) begin
            t = d >> (8 * k);
            ref_mem[(base + k) % MEMB] = t[7:0];
        end
    endfunction

    task automatic issue(input logic w, input logic r, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] d, input bit use_k, input logic [31:0] k);
        exp_t e;
        bit   lb, sb;
        we = w; re = r; funct3 = f3; addr = a; data_in = d;
        lb    = r && !ld_legal(f3, a);
        sb    = w && !st_legal(f3, a);
        e.v   = r;
        e.f   = lb || sb;
        e.cyc = cyc + 1;
        e.d   = (r && !lb) ? (use_k ? k : ref_load(f3, a)) : 32'd0;
        if (w && !sb) ref_store(f3, a, d);
        if (r || e.f) exp_q.push_back(e);
        @(posedge clk); #1;
        we = 1'b0; re = 1'b0;
    endtask

    // Counts cycles from rst release until busy drops, with a store attempt mid-way.
    task automatic count_busy(output int n, output int stray);
        n = 0;
        stray = 0;
        while (n < 400) begin
            we = (n == 10); re = 1'b0; funct3 = 3'b010; addr = 32'h14; data_in = 32'hDEADBEEF;
            @(posedge clk); #1;
            n++;
            if (valid || fault) stray++;
            if (!busy) break;
        end
        we = 1'b0;
    endtask

    // Monitor: pops one expectation per presented output and checks data hold otherwise.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (mon_en) begin
                if (valid || fault) begin
                    ntests++;
                    if (exp_q.size() == 0) begin
                        nfail++;
                        $display("FAIL unexpected_output: valid=%0b fault=%0b, nothing expected", valid, fault);
                    end else begin
                        e = exp_q.pop_front();
                        chk("out_cycle", 32'(cyc), 32'(e.cyc));
                        chk("valid", 32'(valid), 32'(e.v));
                        chk("fault", 32'(fault), 32'(e.f));
                        if (e.v) begin
                            chk("data_out", data_out, e.d);
                            last_dout = e.d;
                        end else begin
                            chk("data_hold", data_out, last_dout);
                        end
                    end
                end else begin
                    chk("data_hold", data_out, last_dout);
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int          n, stray;
        logic [2:0]  f3;
        logic [31:0] a;
        logic        w, r;

        rst = 1'b1; we = 1'b0; re = 1'b0; funct3 = 3'd0; addr = 32'd0; data_in = 32'd0;
        nc_rst = 1'b1; nc_we = 1'b0; nc_re = 1'b0; nc_funct3 = 3'd0; nc_addr = 32'd0; nc_data_in = 32'd0;
        mon_en = 1'b0; last_dout = 32'd0;
        for (int i = 0; i < MEMB; i++) ref_mem[i] = 8'h00;

        repeat (2) @(posedge clk); #1;
        chk("reset_data_out", data_out, 32'd0);
        chk("reset_valid", 32'(valid), 32'd0);
        chk("reset_fault", 32'(fault), 32'd0);
        chk("reset_busy", 32'(busy), 32'd1);

        rst = 1'b0;
        count_busy(n, stray);
        chk("busy_cycles", 32'(n), 32'd256);
        chk("busy_no_output", 32'(stray), 32'd0);
        mon_en = 1'b1;

        issue(1'b0, 1'b1, 3'b010, 32'h14, 32'd0, 1'b1, 32'h00000000);
        issue(1'b1, 1'b0, 3'b010, 32'h10, 32'h11223344, 1'b0, 32'd0);
        issue(1'b1, 1'b0, 3'b000, 32'h12, 32'h00000080, 1'b0, 32'd0);
        issue(1'b1, 1'b0, 3'b001, 32'h10, 32'h0000BEEF, 1'b0, 32'd0);
        issue(1'b0, 1'b1, 3'b010, 32'h10, 32'd0, 1'b1, 32'h1180BEEF);
        issue(1'b0, 1'b1, 3'b000, 32'h12, 32'd0, 1'b1, 32'hFFFFFF80);
        issue(1'b0, 1'b1, 3'b100, 32'h12, 32'd0, 1'b1, 32'h00000080);
        issue(1'b0, 1'b1, 3'b001, 32'h10, 32'd0, 1'b1, 32'hFFFFBEEF);
        issue(1'b0, 1'b1, 3'b101, 32'h10, 32'd0, 1'b1, 32'h0000BEEF);

        issue(1'b0, 1'b1, 3'b010, 32'h11, 32'd0, 1'b0, 32'd0);
        issue(1'b1, 1'b0, 3'b001, 32'h13, 32'h0000AAAA, 1'b0, 32'd0);
        issue(1'b0, 1'b1, 3'b010, 32'h10, 32'd0, 1'b1, 32'h1180BEEF);
        issue(1'b0, 1'b1, 3'b011, 32'h10, 32'd0, 1'b0, 32'd0);
        issue(1'b1, 1'b0, 3'b100, 32'h10, 32'h0, 1'b0, 32'd0);

        issue(1'b1, 1'b0, 3'b010, 32'h20, 32'h00000005, 1'b0, 32'd0);
        issue(1'b1, 1'b1, 3'b010, 32'h20, 32'h00000009, 1'b1, 32'h00000005);
        issue(1'b0, 1'b1, 3'b010, 32'h20, 32'd0, 1'b1, 32'h00000009);
        issue(1'b0, 1'b1, 3'b010, 32'h20, 32'd0, 1'b1, 32'h00000009);
        issue(1'b0, 1'b1, 3'b010, 32'h20, 32'd0, 1'b1, 32'h00000009);
        issue(1'b1, 1'b1, 3'b100, 32'h21, 32'h00000077, 1'b1, 32'h00000000);

        issue(1'b1, 1'b0, 3'b010, 32'h400, 32'hCAFEF00D, 1'b0, 32'd0);
        issue(1'b0, 1'b1, 3'b010, 32'h0, 32'd0, 1'b1, 32'hCAFEF00D);

        for (int i = 0; i < 400; i++) begin
            f3 = f3_tbl[$urandom_range(0, 7)];
            a  = $urandom();
            if ($urandom_range(0, 3) != 0) a = a & 32'h0000003F;
            if ($urandom_range(0, 1) != 0) a[1:0] = 2'b00;
            w = 1'($urandom_range(0, 1));
            r = 1'($urandom_range(0, 1));
            issue(w, r, f3, a, $urandom(), 1'b0, 32'd0);
        end

        repeat (3) @(posedge clk); #1;
        mon_en = 1'b0;
        rst = 1'b1;
        repeat (2) @(posedge clk); #1;
        rst = 1'b0;
        repeat (100) @(posedge clk); #1;
        chk("busy_mid_clear", 32'(busy), 32'd1);
        rst = 1'b1;
        repeat (2) @(posedge clk); #1;
        rst = 1'b0;
        count_busy(n, stray);
        chk("busy_cycles_restart", 32'(n), 32'd256);
        for (int i = 0; i < MEMB; i++) ref_mem[i] = 8'h00;
        last_dout = 32'd0;
        mon_en = 1'b1;
        for (int i = 0; i < 24; i++) begin
            a = {22'd0, 8'($urandom_range(0, 255)), 2'b00};
            if (i < 8) a = 32'(4 * i);
            issue(1'b0, 1'b1, 3'b010, a, 32'd0, 1'b0, 32'd0);
        end

        chk("nc_reset_busy", 32'(nc_busy), 32'd1);
        chk("nc_reset_valid", 32'(nc_valid), 32'd0);
        chk("nc_reset_data", nc_data_out, 32'd0);
        nc_rst = 1'b0;
        @(posedge clk); #1;
        chk("nc_busy_release", 32'(nc_busy), 32'd0);
        nc_we = 1'b1; nc_funct3 = 3'b010; nc_addr = 32'h48; nc_data_in = 32'h12345678;
        @(posedge clk); #1;
        nc_we = 1'b0;
        nc_rst = 1'b1;
        repeat (2) @(posedge clk); #1;
        nc_rst = 1'b0;
        @(posedge clk); #1;
        chk("nc_busy_after_reset", 32'(nc_busy), 32'd0);
        nc_re = 1'b1; nc_funct3 = 3'b010; nc_addr = 32'h08;
        @(posedge clk); #1;
        nc_re = 1'b0;
        chk("nc_valid", 32'(nc_valid), 32'd1);
        chk("nc_fault", 32'(nc_fault), 32'd0);
        chk("nc_survive", nc_data_out, 32'h12345678);
        @(posedge clk); #1;
        chk("nc_valid_pulse", 32'(nc_valid), 32'd0);

        repeat (3) @(posedge clk); #1;
        chk("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end
endmodule
